and3_gate: RTL and testbench
============================

// Module: and3_gate
// PURPOSE
//  Bitwise 3-input AND across WIDTH lanes: y = a & b & c.
//  The combinational result is available immediately.
//  Also provides a one-cycle registered copy with valid tracking, and a saturating count of all-ones results.
//  Used as a glue/qualifier primitive wherever three enables must coincide.
// PARAMETERS
//  WIDTH  1   lane count of a, b, c, y, y_q (>=1)
//  CNT_W  8   width of hit_cnt (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      reset, asynchronous, active-low
//  a          in   WIDTH  operand a
//  b          in   WIDTH  operand b
//  c          in   WIDTH  operand c
//  in_valid   in   1      a/b/c qualify this cycle
//  clear      in   1      synchronous clear of y_q, out_valid, hit_cnt
//  y          out  WIDTH  combinational a & b & c
//  y_q        out  WIDTH  registered a & b & c
//  out_valid  out  1      y_q holds a result captured last cycle
//  y_all      out  1      &y_q when out_valid, else 0
//  hit_cnt    out  CNT_W  saturating count of accepted all-ones results
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - y: purely combinational, y[i] = a[i] & b[i] & c[i].
//    - Zero-cycle latency; independent of clk, rst_n, in_valid, clear.
//    - X/Z on any input propagates per Verilog & semantics.
//  - Reset (rst_n=0, asynchronous):
//    - y_q=0, out_valid=0, hit_cnt=0, y_all=0.
//    - Registers are held while rst_n is low.
//    - y remains live during reset.
//  - Per rising edge, with rst_n=1:
//    - clear=1 (has priority over in_valid): y_q<=0, out_valid<=0, hit_cnt<=0.
//    - else if in_valid=1:
//      - y_q<=a&b&c, out_valid<=1.
//      - if (a&b&c) is all ones, hit_cnt<=hit_cnt+1, saturating at 2^CNT_W-1 (no wrap).
//    - else (in_valid=0): y_q holds, out_valid<=0, hit_cnt holds.
//  - Latency: in_valid at edge N -> y_q/out_valid valid after edge N; one cycle.
//  - y_all = out_valid & (&y_q); combinational from registers.
//  - No backpressure; every in_valid cycle is accepted.
//  - Reset deasserting mid-stream: first accepted sample is the first edge with rst_n=1 and in_valid=1.
// TESTING
//  - Truth table, WIDTH=1, 10 time units per step:
//    - abc = 000,001,010,011,100,101,110 -> y=0.
//    - abc = 111 -> y=1.
//  - Registered path:
//    - in_valid=1, abc=111 at one edge -> next cycle y_q=1, out_valid=1, y_all=1, hit_cnt=1.
//    - in_valid=0 afterwards -> out_valid=0, y_q holds 1.
//  - WIDTH=4: a=4'hF, b=4'hA, c=4'h6 -> y=4'h2.
//    - With in_valid=1 -> y_q=4'h2, y_all=0, hit_cnt unchanged.
//  - Saturation, CNT_W=2: 5 accepted all-ones vectors -> hit_cnt=3, no wrap to 0.
//  - clear and in_valid both 1 with abc=111 -> y_q=0, out_valid=0, hit_cnt=0.
//  - Async reset: drop rst_n mid-cycle after hits -> hit_cnt=0 and y_q=0 immediately (before next clk edge).
//    - y still follows a&b&c during reset.

Source files
------------

// File: rtl/and3_gate.sv
// and3_gate: lane-wise 3-input AND with a registered copy, a valid flag and a
// saturating count of accepted all-ones results.
module and3_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             in_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  output logic             y_all,
  output logic [CNT_W-1:0] hit_cnt
);

  // Combinational AND: live regardless of clock, reset or qualifiers.
  assign y = a & b & c;

  // Capture qualified results; clear wins over in_valid, the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      hit_cnt   <= '0;
    end else if (clear) begin
      y_q       <= '0;
      out_valid <= 1'b0;
      hit_cnt   <= '0;
    end else if (in_valid) begin
      y_q       <= y;
      out_valid <= 1'b1;
      if ((&y) && (hit_cnt != {CNT_W{1'b1}}))
        hit_cnt <= hit_cnt + CNT_W'(1);
    end else begin
      out_valid <= 1'b0;
    end
  end

  // All-ones flag only meaningful while the registered copy is valid.
  assign y_all = out_valid & (&y_q);

endmodule

// File: tb/tb_and3_gate.sv
// Self-checking bench for and3_gate (WIDTH=4, CNT_W=2).
module tb_and3_gate;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] a, b, c;
  logic             in_valid;
  logic             clear;
  logic [WIDTH-1:0] y, y_q;
  logic             out_valid, y_all;
  logic [CNT_W-1:0] hit_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (spec-level view of the registered path).
  logic [WIDTH-1:0] exp_yq;
  logic             exp_ov;
  int               exp_cnt;

  and3_gate #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c),
    .in_valid(in_valid), .clear(clear),
    .y(y), .y_q(y_q), .out_valid(out_valid), .y_all(y_all), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, ".y_q"}, 32'(y_q), 32'(exp_yq));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    check_eq({tag, ".y_all"}, 32'(y_all), 32'(exp_ov && (exp_yq == ONES)));
    check_eq({tag, ".hit_cnt"}, 32'(hit_cnt), 32'(exp_cnt));
  endtask

  // Apply one cycle of stimulus, check y combinationally, then the registers.
  task automatic step(input string tag, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                      input logic [WIDTH-1:0] vc, input logic viv, input logic vclr);
    logic [WIDTH-1:0] r;
    a = va; b = vb; c = vc; in_valid = viv; clear = vclr;
    #1;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = va[i] && vb[i] && vc[i];
    check_eq({tag, ".y"}, 32'(y), 32'(r));
    @(posedge clk);
    if (vclr) begin
      exp_yq = '0; exp_ov = 1'b0; exp_cnt = 0;
    end else if (viv) begin
      exp_yq = r; exp_ov = 1'b1;
      if (r == ONES) exp_cnt = (exp_cnt + 1 > CNT_MAX) ? CNT_MAX : exp_cnt + 1;
    end else begin
      exp_ov = 1'b0;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [2:0] abc;
    logic [WIDTH-1:0] ra, rb, rc;
    rst_n = 1'b0; a = '0; b = '0; c = '0; in_valid = 1'b0; clear = 1'b0;
    exp_yq = '0; exp_ov = 1'b0; exp_cnt = 0;
    #2;
    check_regs("reset");
    a = 4'hF; b = 4'h5; c = 4'h7; #1;
    check_eq("reset.y_live", 32'(y), 32'h5);
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Truth table, each combination replicated across all lanes.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      step("tt", {WIDTH{abc[2]}}, {WIDTH{abc[1]}}, {WIDTH{abc[0]}}, 1'b1, 1'b0);
    end
    check_eq("tt.hit1", 32'(hit_cnt), 32'd1);
    step("hold", '0, '0, '0, 1'b0, 1'b0);
    check_eq("hold.y_q", 32'(y_q), 32'(ONES));

    step("mixed", 4'hF, 4'hA, 4'h6, 1'b1, 1'b0);
    check_eq("mixed.y_q", 32'(y_q), 32'h2);

    // Saturation: five accepted all-ones vectors into a 2-bit counter.
    step("clr", '0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step("sat", ONES, ONES, ONES, 1'b1, 1'b0);
    check_eq("sat.cnt", 32'(hit_cnt), 32'd3);

    step("clr_prio", ONES, ONES, ONES, 1'b1, 1'b1);

    // Randomized traffic biased toward all-ones operands.
    for (int i = 0; i < 200; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? 4'(($urandom)) : ONES;
      rb = ($urandom_range(0, 2) == 0) ? 4'(($urandom)) : ONES;
      rc = ($urandom_range(0, 2) == 0) ? 4'(($urandom)) : ONES;
      step("rnd", ra, rb, rc, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

    // Async reset mid-cycle after hits.
    step("pre_rst", ONES, ONES, ONES, 1'b1, 1'b0);
    step("pre_rst", ONES, ONES, ONES, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    exp_yq = '0; exp_ov = 1'b0; exp_cnt = 0;
    #1;
    check_regs("async_rst");
    a = 4'hC; b = 4'hE; c = 4'h7; #1;
    check_eq("async_rst.y_live", 32'(y), 32'h4);
    a = ONES; b = ONES; c = ONES; in_valid = 1'b1;
    @(posedge clk); #1;
    check_regs("rst_held");
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_yq = ONES; exp_ov = 1'b1; exp_cnt = 1;
    check_regs("first_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
